// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU fetch configuration: default widths, PC step and the fetch FSM encoding.
package fetch_ctrl_pkg;

   localparam int AddrWidth   = 32;
   localparam int InstWidth   = 32;
   localparam int PcIncrement = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding ICache request, a single-entry
// output buffer toward decode, and redirect handling that drains stale responses.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int              ADDR     = AddrWidth,
   parameter int              INST     = InstWidth,
   parameter logic [ADDR-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset_,

   output logic            ic_req,
   output logic [ADDR-1:0] ic_addr,
   input  logic            ic_ready,
   input  logic            ic_valid,
   input  logic [INST-1:0] ic_inst,

   output logic            inst_valid,
   output logic [INST-1:0] inst,
   output logic [ADDR-1:0] inst_pc,
   input  logic            dec_stall,

   input  logic            redirect_valid,
   input  logic [ADDR-1:0] redirect_pc
);

   fetch_state_e    state_q, state_d;
   logic [ADDR-1:0] pc_q, pc_d;
   logic [ADDR-1:0] inst_pc_q;
   logic [INST-1:0] inst_q;
   logic            inst_valid_q, inst_valid_d;
   logic            req;
   logic            load;
   logic            consume;
   logic [ADDR-1:0] redirect_aligned;

   assign redirect_aligned = redirect_pc & ~ADDR'(3);
   assign consume          = inst_valid_q && !dec_stall;

   // A response is only accepted into the buffer from WAIT; DRAIN swallows the
   // reply to a request that a redirect made stale.
   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            req = !(inst_valid_q && dec_stall);
            if (req && ic_ready) begin
               state_d = redirect_valid ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (ic_valid) begin
               state_d = REQ;
               load    = !redirect_valid;
            end else if (redirect_valid) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ic_valid) begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_aligned;
      end else if (load) begin
         pc_d = pc_q + ADDR'(PcIncrement);
      end
   end

   always_comb begin
      inst_valid_d = inst_valid_q;
      if (redirect_valid) begin
         inst_valid_d = 1'b0;
      end else if (load) begin
         inst_valid_d = 1'b1;
      end else if (consume) begin
         inst_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
         if (load) begin
            inst_q    <= ic_inst;
            inst_pc_q <= pc_q;
         end
      end
   end

   assign ic_req     = req;
   assign ic_addr    = pc_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// against a request/response-level reference model.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset_;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_ready;
   logic        ic_valid;
   logic [31:0] ic_inst;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        dec_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: started / outstanding request / response-to-discard, plus buffer.
   bit          m_started, m_out, m_disc, m_bv;
   logic [31:0] m_pc, m_bi, m_bpc;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .ADDR     (32),
      .INST     (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .reset_         (reset_),
      .ic_req         (ic_req),
      .ic_addr        (ic_addr),
      .ic_ready       (ic_ready),
      .ic_valid       (ic_valid),
      .ic_inst        (ic_inst),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .dec_stall      (dec_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   task automatic do_reset();
      reset_         = 1'b0;
      ic_ready       = 1'b0;
      ic_valid       = 1'b0;
      ic_inst        = '0;
      dec_stall      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1 reset_ = 1'b1;
   endtask

   task automatic m_reset();
      m_started = 0; m_out = 0; m_disc = 0; m_bv = 0;
      m_pc = RST_PC; m_bi = '0; m_bpc = '0;
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic m_step();
      bit          req, acc, load, consume;
      logic [31:0] npc;
      req     = m_started && !m_out && !(m_bv && dec_stall);
      acc     = req && ic_ready;
      load    = 0;
      consume = m_bv && !dec_stall;
      npc     = m_pc;
      if (!m_started) begin
         m_started = 1;
      end else if (!m_out) begin
         if (acc) begin
            m_out  = 1;
            m_disc = redirect_valid;
         end
      end else if (ic_valid) begin
         m_out  = 0;
         load   = !m_disc && !redirect_valid;
         m_disc = 0;
      end else if (redirect_valid) begin
         m_disc = 1;
      end
      if (redirect_valid) npc = redirect_pc & 32'hFFFF_FFFC;
      else if (load)      npc = m_pc + 32'd4;
      if (redirect_valid) m_bv = 0;
      else if (load) begin
         m_bv  = 1;
         m_bi  = ic_inst;
         m_bpc = m_pc;
      end else if (consume) m_bv = 0;
      m_pc = npc;
   endtask

   task automatic test_reset();
      reset_ = 1'b0; ic_ready = 1'b1; ic_valid = 1'b1; ic_inst = 32'h5555_AAAA;
      dec_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (ic_req !== 1'b0) begin miscompares++; $display("FAIL rst_ic_req: got %b expected 0", ic_req); end
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
      vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h expected 0", inst); end
      vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
      vectors++; if (ic_addr !== RST_PC) begin miscompares++; $display("FAIL rst_ic_addr: got %h expected %h", ic_addr, RST_PC); end
      ic_ready = 1'b0; ic_valid = 1'b0;
      @(posedge clk); #1 reset_ = 1'b1;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b0) begin miscompares++; $display("FAIL first_cycle_req: got %b expected 0", ic_req); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b1) begin miscompares++; $display("FAIL second_cycle_req: got %b expected 1", ic_req); end
      vectors++; if (ic_addr !== RST_PC) begin miscompares++; $display("FAIL second_cycle_addr: got %h expected %h", ic_addr, RST_PC); end
      @(posedge clk); #1;
      $display("test_reset done, %0d vectors so far", vectors);
   endtask

   task automatic test_fetch_seq();
      logic [31:0] acc_q[$];
      logic [31:0] sent_q[$];
      int          sent_cyc[$];
      logic [31:0] got_inst[$];
      logic [31:0] got_pc[$];
      int          got_cyc[$];
      logic [31:0] a;
      int          gc;
      bit          pend = 0;
      do_reset();
      for (int c = 0; c < 14; c++) begin
         ic_ready = 1'b1; dec_stall = 1'b0; redirect_valid = 1'b0;
         ic_valid = pend;
         ic_inst  = $urandom;
         if (pend) begin sent_q.push_back(ic_inst); sent_cyc.push_back(c); end
         @(negedge clk);
         pend = ic_req && ic_ready;
         if (pend) acc_q.push_back(ic_addr);
         if (inst_valid) begin got_inst.push_back(inst); got_pc.push_back(inst_pc); got_cyc.push_back(c); end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         a = (acc_q.size() > i) ? acc_q[i] : 32'hxxxx_xxxx;
         vectors++; if (a !== RST_PC + 32'(4 * i)) begin miscompares++; $display("FAIL seq_addr%0d: got %h expected %h", i, a, RST_PC + 32'(4 * i)); end
         a = (got_pc.size() > i) ? got_pc[i] : 32'hxxxx_xxxx;
         vectors++; if (a !== RST_PC + 32'(4 * i)) begin miscompares++; $display("FAIL seq_inst_pc%0d: got %h expected %h", i, a, RST_PC + 32'(4 * i)); end
         a = (got_inst.size() > i) ? got_inst[i] : 32'hxxxx_xxxx;
         vectors++; if (sent_q.size() <= i || a !== sent_q[i]) begin miscompares++; $display("FAIL seq_inst%0d: got %h expected %h", i, a, (sent_q.size() > i) ? sent_q[i] : 32'h0); end
         gc = (got_cyc.size() > i) ? got_cyc[i] : -1;
         vectors++; if (sent_cyc.size() <= i || gc != sent_cyc[i] + 1) begin miscompares++; $display("FAIL seq_latency%0d: got cycle %0d expected %0d", i, gc, (sent_cyc.size() > i) ? sent_cyc[i] + 1 : -1); end
      end
      $display("test_fetch_seq done, %0d vectors so far", vectors);
   endtask

   task automatic test_stall();
      logic [31:0] x;
      x = $urandom | 32'h1;
      do_reset();
      ic_ready = 1'b1; dec_stall = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b1) begin miscompares++; $display("FAIL stall_empty_req: got %b expected 1", ic_req); end
      @(posedge clk); #1;
      ic_valid = 1'b1; ic_inst = x;
      @(posedge clk); #1;
      ic_valid = 1'b0; ic_inst = ~x;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vectors++; if (ic_req !== 1'b0) begin miscompares++; $display("FAIL stall_req%0d: got %b expected 0", k, ic_req); end
         vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid%0d: got %b expected 1", k, inst_valid); end
         vectors++; if (inst !== x) begin miscompares++; $display("FAIL stall_inst%0d: got %h expected %h", k, inst, x); end
         vectors++; if (inst_pc !== RST_PC) begin miscompares++; $display("FAIL stall_inst_pc%0d: got %h expected %h", k, inst_pc, RST_PC); end
         @(posedge clk); #1;
      end
      dec_stall = 1'b0;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b1) begin miscompares++; $display("FAIL stall_release_req: got %b expected 1", ic_req); end
      vectors++; if (ic_addr !== RST_PC + 32'd4) begin miscompares++; $display("FAIL stall_release_addr: got %h expected %h", ic_addr, RST_PC + 32'd4); end
      @(posedge clk); #1;
      $display("test_stall done, %0d vectors so far", vectors);
   endtask

   task automatic test_redirect_wait();
      do_reset();
      ic_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b0) begin miscompares++; $display("FAIL drain_req: got %b expected 0", ic_req); end
      vectors++; if (ic_addr !== 32'h0000_2000) begin miscompares++; $display("FAIL drain_addr: got %h expected 00002000", ic_addr); end
      @(posedge clk); #1;
      ic_valid = 1'b1; ic_inst = 32'hDEAD_BEEF;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b0) begin miscompares++; $display("FAIL drain_req2: got %b expected 0", ic_req); end
      @(posedge clk); #1;
      ic_valid = 1'b0;
      @(negedge clk);
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL drain_discard: got %b expected 0", inst_valid); end
      vectors++; if (ic_req !== 1'b1) begin miscompares++; $display("FAIL drain_resume_req: got %b expected 1", ic_req); end
      vectors++; if (ic_addr !== 32'h0000_2000) begin miscompares++; $display("FAIL drain_resume_addr: got %h expected 00002000", ic_addr); end
      @(posedge clk); #1;
      $display("test_redirect_wait done, %0d vectors so far", vectors);
   endtask

   task automatic test_redirect_same();
      do_reset();
      ic_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ic_valid = 1'b1; ic_inst = 32'h1234_5678;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
      @(posedge clk); #1;
      ic_valid = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL same_no_load: got %b expected 0", inst_valid); end
      vectors++; if (ic_req !== 1'b1) begin miscompares++; $display("FAIL same_req: got %b expected 1", ic_req); end
      vectors++; if (ic_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL same_addr: got %h expected 00003000", ic_addr); end
      @(posedge clk); #1;
      $display("test_redirect_same done, %0d vectors so far", vectors);
   endtask

   task automatic test_wrap();
      logic [31:0] y;
      y = $urandom;
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      redirect_valid = 1'b0; ic_ready = 1'b1;
      @(negedge clk);
      vectors++; if (ic_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_start_addr: got %h expected fffffffc", ic_addr); end
      @(posedge clk); #1;
      ic_valid = 1'b1; ic_inst = y;
      @(posedge clk); #1;
      ic_valid = 1'b0;
      @(negedge clk);
      vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid: got %b expected 1", inst_valid); end
      vectors++; if (inst_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_inst_pc: got %h expected fffffffc", inst_pc); end
      vectors++; if (inst !== y) begin miscompares++; $display("FAIL wrap_inst: got %h expected %h", inst, y); end
      vectors++; if (ic_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_addr: got %h expected 00000000", ic_addr); end
      @(posedge clk); #1;
      $display("test_wrap done, %0d vectors so far", vectors);
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      v = $urandom | 32'h1;
      do_reset();
      ic_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ic_valid = 1'b1; ic_inst = v;
      @(posedge clk); #1;
      ic_valid = 1'b0;
      @(posedge clk); #1;
      vectors++; if (ic_addr !== RST_PC + 32'd4) begin miscompares++; $display("FAIL arst_pre_addr: got %h expected %h", ic_addr, RST_PC + 32'd4); end
      #2 reset_ = 1'b0;
      #1;
      vectors++; if (ic_req !== 1'b0) begin miscompares++; $display("FAIL arst_req: got %b expected 0", ic_req); end
      vectors++; if (ic_addr !== RST_PC) begin miscompares++; $display("FAIL arst_addr: got %h expected %h", ic_addr, RST_PC); end
      vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL arst_inst: got %h expected 0", inst); end
      vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL arst_inst_pc: got %h expected 0", inst_pc); end
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b expected 0", inst_valid); end
      @(posedge clk); #1 reset_ = 1'b1;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b0) begin miscompares++; $display("FAIL arst_restart_idle: got %b expected 0", ic_req); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (ic_req !== 1'b1) begin miscompares++; $display("FAIL arst_restart_req: got %b expected 1", ic_req); end
      vectors++; if (ic_addr !== RST_PC) begin miscompares++; $display("FAIL arst_restart_addr: got %h expected %h", ic_addr, RST_PC); end
      @(posedge clk); #1;
      $display("test_async_reset done, %0d vectors so far", vectors);
   endtask

   task automatic test_random();
      bit exp_req;
      do_reset();
      m_reset();
      for (int c = 0; c < 3000; c++) begin
         ic_ready       = ($urandom_range(3) != 0);
         ic_valid       = ($urandom_range(1) != 0);
         dec_stall      = ($urandom_range(9) < 3);
         redirect_valid = ($urandom_range(19) == 0);
         redirect_pc    = $urandom;
         ic_inst        = $urandom;
         @(negedge clk);
         exp_req = m_started && !m_out && !(m_bv && dec_stall);
         vectors++; if (ic_req !== exp_req) begin miscompares++; $display("FAIL rnd_req c%0d: got %b expected %b", c, ic_req, exp_req); end
         vectors++; if (ic_addr !== m_pc) begin miscompares++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, ic_addr, m_pc); end
         vectors++; if (inst_valid !== m_bv) begin miscompares++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, inst_valid, m_bv); end
         vectors++; if (inst !== m_bi) begin miscompares++; $display("FAIL rnd_inst c%0d: got %h expected %h", c, inst, m_bi); end
         vectors++; if (inst_pc !== m_bpc) begin miscompares++; $display("FAIL rnd_inst_pc c%0d: got %h expected %h", c, inst_pc, m_bpc); end
         m_step();
         @(posedge clk); #1;
      end
      $display("test_random done, %0d vectors so far", vectors);
   endtask

   initial begin
      reset_ = 1'b0;
      test_reset();
      test_fetch_seq();
      test_stall();
      test_redirect_wait();
      test_redirect_same();
      test_wrap();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
